// File: rtl/mem_if_pkg.sv
// Shared definitions for the cache-side memory interface and its responder.
package mem_if_pkg;

    localparam int MEM_ADDR_W  = 27;
    localparam int MEM_BLOCK_W = 256;
    localparam int MAX_LATENCY = 255;
    localparam int CNT_W       = 8;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

endpackage

// File: rtl/mem_block_store.sv
// Single-port block array with registered read and per-block valid bits.
module mem_block_store
    import mem_if_pkg::*;
#(
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [DEPTH_LOG2-1:0]  addr,
    input  logic                   we,
    input  logic                   rd,
    input  logic [MEM_BLOCK_W-1:0] wdata,
    output logic [MEM_BLOCK_W-1:0] rdata
);

    localparam int DEPTH = 2 ** DEPTH_LOG2;

    logic [MEM_BLOCK_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]       valid;

    // Array contents are deliberately left unreset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= '0;
            rdata <= '0;
        end else begin
            if (we) begin
                valid[addr] <= 1'b1;
            end
            if (rd) begin
                rdata <= valid[addr] ? mem[addr] : '0;
            end
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Backing-store responder: one block request at a time, fixed latency,
// completed by a single-cycle mem_ready pulse.
module mem_responder
    import mem_if_pkg::*;
#(
    parameter int LATENCY    = 4,
    parameter int DEPTH_LOG2 = 10
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   mem_read,
    input  logic                   mem_write,
    input  logic [MEM_ADDR_W-1:0]  mem_addr,
    input  logic [MEM_BLOCK_W-1:0] mem_wdata,
    output logic [MEM_BLOCK_W-1:0] mem_rdata,
    output logic                   mem_ready,
    output logic                   req_err
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_t                 state;
    state_t                 state_n;
    logic [CNT_W-1:0]       cnt;
    logic                   op_write;
    logic [DEPTH_LOG2-1:0]  idx;
    logic [MEM_BLOCK_W-1:0] wdata_q;
    logic                   req;
    logic                   st_we;
    logic                   st_rd;
    logic [DEPTH_LOG2-1:0]  st_addr;
    logic                   unused_addr_hi;

    assign req            = mem_read | mem_write;
    assign unused_addr_hi = ^mem_addr[MEM_ADDR_W-1:DEPTH_LOG2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    always_comb begin
        state_n = state;
        unique case (state)
            IDLE: begin
                if (req) begin
                    state_n = (LATENCY == 1) ? RESP : BUSY;
                end
            end
            BUSY: begin
                if (cnt == CNT_W'(1)) begin
                    state_n = RESP;
                end
            end
            RESP:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // The store is addressed straight from the bus in IDLE so a
    // LATENCY=1 read can register its data on the accepting edge.
    always_comb begin
        mem_ready = 1'b0;
        st_we     = 1'b0;
        st_rd     = 1'b0;
        st_addr   = idx;
        unique case (state)
            IDLE: begin
                st_addr = mem_addr[DEPTH_LOG2-1:0];
                st_rd   = !mem_write && (state_n == RESP);
            end
            BUSY: begin
                st_rd = !op_write && (state_n == RESP);
            end
            RESP: begin
                mem_ready = 1'b1;
                st_we     = op_write && !rst;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt      <= '0;
            op_write <= 1'b0;
            idx      <= '0;
            wdata_q  <= '0;
            req_err  <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        op_write <= mem_write;
                        idx      <= mem_addr[DEPTH_LOG2-1:0];
                        wdata_q  <= mem_wdata;
                        cnt      <= CNT_INIT;
                        if (mem_read && mem_write) begin
                            req_err <= 1'b1;
                        end
                    end
                end
                BUSY:    cnt <= cnt - CNT_W'(1);
                default: ;
            endcase
        end
    end

    mem_block_store #(
        .DEPTH_LOG2(DEPTH_LOG2)
    ) u_store (
        .clk  (clk),
        .rst  (rst),
        .addr (st_addr),
        .we   (st_we),
        .rd   (st_rd),
        .wdata(wdata_q),
        .rdata(mem_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Scoreboard bench for mem_responder: one LATENCY=4 and one LATENCY=1
// instance, driven in turn by directed and random block requests.
module tb_mem_responder;

    localparam int NDUT = 2;
    localparam int LAT0 = 4;
    localparam int LAT1 = 1;
    localparam int DL2  = 10;

    typedef struct {
        int           d;
        longint       due;
        bit           is_rd;
        logic [255:0] data;
        bit           err;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         rd    [NDUT];
    logic         wr    [NDUT];
    logic [26:0]  addr  [NDUT];
    logic [255:0] wdata [NDUT];
    logic [255:0] rdata [NDUT];
    logic         rdy   [NDUT];
    logic         err   [NDUT];

    int           lat [NDUT] = '{LAT0, LAT1};
    longint       cyc = 0;
    longint       free_at [NDUT];
    int           checks = 0;
    int           errors = 0;
    exp_t         expq[$];
    logic [255:0] model[int];
    bit           exp_err [NDUT];
    logic [255:0] exp_rd  [NDUT];

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    mem_responder #(.LATENCY(LAT0), .DEPTH_LOG2(DL2)) u_dut0 (
        .clk      (clk),
        .rst      (rst),
        .mem_read (rd[0]),
        .mem_write(wr[0]),
        .mem_addr (addr[0]),
        .mem_wdata(wdata[0]),
        .mem_rdata(rdata[0]),
        .mem_ready(rdy[0]),
        .req_err  (err[0])
    );

    mem_responder #(.LATENCY(LAT1), .DEPTH_LOG2(DL2)) u_dut1 (
        .clk      (clk),
        .rst      (rst),
        .mem_read (rd[1]),
        .mem_write(wr[1]),
        .mem_addr (addr[1]),
        .mem_wdata(wdata[1]),
        .mem_rdata(rdata[1]),
        .mem_ready(rdy[1]),
        .req_err  (err[1])
    );

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    function automatic int mkey(input int d, input logic [26:0] a);
        return d * (1 << DL2) + (int'(a) & ((1 << DL2) - 1));
    endfunction

    // Monitor: every presented mem_ready consumes the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int d = 0; d < NDUT; d++) begin
                if (rdy[d]) begin
                    if (expq.size() == 0 || expq[0].d != d) begin
                        chk($sformatf("spurious_ready%0d", d),
                            256'(rdy[d]), 256'(0));
                    end else begin
                        e = expq.pop_front();
                        chk($sformatf("ready_cycle%0d", d),
                            256'(cyc), 256'(e.due));
                        chk($sformatf("req_err%0d", d),
                            256'(err[d]), 256'(e.err));
                        if (e.is_rd) begin
                            chk($sformatf("read_data%0d", d),
                                rdata[d], e.data);
                            exp_rd[d] = e.data;
                        end
                    end
                end else begin
                    chk($sformatf("rdata_hold%0d", d), rdata[d], exp_rd[d]);
                end
            end
            if (expq.size() > 0 && cyc > expq[0].due) begin
                chk("ready_timeout", 256'(cyc), 256'(expq[0].due));
                void'(expq.pop_front());
            end
        end
    end

    // Called #1 after a falling edge; reset holds for n rising edges.
    task automatic do_reset(input int n);
        rst = 1'b1;
        expq.delete();
        model.delete();
        for (int d = 0; d < NDUT; d++) begin
            exp_err[d] = 1'b0;
            exp_rd[d]  = '0;
            rd[d]      = 1'b0;
            wr[d]      = 1'b0;
        end
        repeat (n) @(negedge clk);
        #1;
        rst = 1'b0;
        for (int d = 0; d < NDUT; d++) free_at[d] = cyc + 1;
    endtask

    task automatic issue(input int d, input bit r, input bit w,
                         input logic [26:0] a, input logic [255:0] dat,
                         input bit hold, output longint at);
        exp_t   e;
        longint acc;
        int     key;
        @(negedge clk);
        while (cyc + 1 < free_at[d]) @(negedge clk);
        rd[d]    = r;
        wr[d]    = w;
        addr[d]  = a;
        wdata[d] = dat;
        acc        = cyc + 1;
        free_at[d] = acc + lat[d] + 1;
        key     = mkey(d, a);
        e.d     = d;
        e.due   = acc + lat[d] - 1;
        e.is_rd = r && !w;
        e.data  = model.exists(key) ? model[key] : '0;
        if (w) model[key] = dat;
        if (r && w) exp_err[d] = 1'b1;
        e.err = exp_err[d];
        expq.push_back(e);
        at = -1;
        if (hold) begin
            for (int i = 0; i < 600; i++) begin
                @(negedge clk);
                if (rdy[d]) begin
                    at = cyc;
                    break;
                end
            end
            chk($sformatf("hold_ready%0d", d), 256'(rdy[d]), 256'(1));
        end else begin
            @(negedge clk);
        end
        rd[d] = 1'b0;
        wr[d] = 1'b0;
    endtask

    // Start a write and reset two edges later (or at the end of RESP
    // when the latency is shorter than that).
    task automatic abort_write(input int d, input logic [26:0] a);
        exp_t   e;
        longint acc;
        int     rs;
        @(negedge clk);
        while (cyc + 1 < free_at[d]) @(negedge clk);
        rd[d]    = 1'b0;
        wr[d]    = 1'b1;
        addr[d]  = a;
        wdata[d] = {8{32'hCAFEF00D}};
        acc = cyc + 1;
        rs  = (lat[d] > 2) ? 2 : lat[d];
        if (lat[d] <= rs) begin
            e.d     = d;
            e.due   = acc + lat[d] - 1;
            e.is_rd = 1'b0;
            e.data  = '0;
            e.err   = exp_err[d];
            expq.push_back(e);
        end
        while (cyc < acc + rs - 1) @(negedge clk);
        #1;
        do_reset(1);
    endtask

    initial begin
        longint       t1;
        longint       t2;
        logic [26:0]  a;
        logic [255:0] dat;
        int           op;
        for (int d = 0; d < NDUT; d++) begin
            rd[d]      = 1'b0;
            wr[d]      = 1'b0;
            addr[d]    = '0;
            wdata[d]   = '0;
            exp_err[d] = 1'b0;
            exp_rd[d]  = '0;
            free_at[d] = 0;
        end
        do_reset(2);
        @(negedge clk);
        for (int d = 0; d < NDUT; d++) begin
            chk("rst_ready", 256'(rdy[d]), 256'(0));
            chk("rst_rdata", rdata[d], 256'(0));
            chk("rst_err", 256'(err[d]), 256'(0));
        end

        issue(0, 1, 0, 27'h5, '0, 1, t1);
        issue(0, 0, 1, 27'h1A3, {8{32'hDEADBEEF}}, 1, t1);
        issue(0, 1, 0, 27'h1A3, '0, 1, t1);
        repeat (6) @(negedge clk);

        issue(0, 0, 1, 27'h40003C0, {8{32'h0BADF00D}}, 1, t1);
        issue(0, 0, 1, 27'h040, {8{32'h12345678}}, 1, t1);
        issue(0, 1, 0, 27'h7C0, '0, 1, t2);
        chk("miss_spacing", 256'(t2 - t1), 256'(LAT0 + 1));

        issue(0, 1, 0, 27'h1A3, '0, 0, t1);
        repeat (12) @(negedge clk);

        issue(0, 1, 1, 27'h77, 256'h1, 1, t1);
        chk("conflict_err", 256'(err[0]), 256'(1));
        issue(0, 1, 0, 27'h77, '0, 1, t1);
        chk("conflict_sticky", 256'(err[0]), 256'(1));

        abort_write(0, 27'h10);
        @(negedge clk);
        chk("abort_err_clr", 256'(err[0]), 256'(0));
        repeat (8) @(negedge clk);
        issue(0, 1, 0, 27'h10, '0, 1, t1);

        issue(1, 0, 1, 27'h2B, {8{32'hA5A55A5A}}, 1, t1);
        issue(1, 1, 0, 27'h2B, '0, 1, t2);
        chk("l1_spacing", 256'(t2 - t1), 256'(LAT1 + 1));
        abort_write(1, 27'h10);
        repeat (4) @(negedge clk);
        issue(1, 1, 0, 27'h10, '0, 1, t1);

        for (int d = 0; d < NDUT; d++) begin
            for (int i = 0; i < 120; i++) begin
                op = $urandom_range(0, 9);
                a = 27'($urandom);
                a[9:0] = 10'($urandom_range(0, 15));
                for (int k = 0; k < 8; k++) dat[k*32 +: 32] = $urandom;
                issue(d, op <= 4 || op == 9, op >= 5, a, dat,
                      $urandom_range(0, 3) != 0, t1);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        repeat (12) @(negedge clk);
        chk("queue_drained", 256'(expq.size()), 256'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

endmodule
